// File: rtl/roi_serial_harness.sv
// Serial-in / serial-out harness around a fuzzer ROI: one shift chain
// di -> din_shr -> dout_shr -> do, with strobe-driven transfer, frame tracking and error flag.
module roi_serial_harness #(
    parameter int unsigned DIN_N    = 8,
    parameter int unsigned DOUT_N   = 8,
    parameter int unsigned AUTO_STB = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sen_i,
    input  logic              di_i,
    input  logic              stb_i,
    output logic              do_o,
    output logic [DIN_N-1:0]  din_o,
    input  logic [DOUT_N-1:0] dout_i,
    output logic              ready_o,
    output logic              frame_err_o,
    output logic [CNT_W-1:0]  frame_cnt_o
);

    localparam int unsigned CntW = $clog2(DIN_N + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(DIN_N);

    logic [DIN_N-1:0]  din_shr_q, din_shr_d;
    logic [DOUT_N-1:0] dout_shr_q, dout_shr_d;
    logic [DIN_N-1:0]  din_q, din_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              frame_err_q, frame_err_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

    logic [DIN_N-1:0]  din_shift;
    logic [DOUT_N-1:0] dout_shift;
    logic              strobe;

    // Width-1 registers have no lower slice to keep, so they simply load their input.
    if (DIN_N == 1) begin : g_din_w1
        assign din_shift = di_i;
    end else begin : g_din_wn
        assign din_shift = {din_shr_q[DIN_N-2:0], di_i};
    end

    if (DOUT_N == 1) begin : g_dout_w1
        assign dout_shift = din_shr_q[DIN_N-1];
    end else begin : g_dout_wn
        assign dout_shift = {dout_shr_q[DOUT_N-2:0], din_shr_q[DIN_N-1]};
    end

    // Auto and external strobes in the same cycle merge into a single transfer.
    assign strobe = stb_i | ((AUTO_STB != 0) && (cnt_q == CntFull));

    always_comb begin
        din_shr_d   = din_shr_q;
        dout_shr_d  = dout_shr_q;
        din_d       = din_q;
        cnt_d       = cnt_q;
        frame_err_d = frame_err_q;
        frame_cnt_d = frame_cnt_q;

        if (sen_i) begin
            din_shr_d  = din_shift;
            dout_shr_d = dout_shift;
        end

        if (strobe) begin
            din_d       = din_shr_q;
            dout_shr_d  = dout_i;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            if (cnt_q != CntFull) begin
                frame_err_d = 1'b1;
            end
            // The bit shifted in on a strobe cycle already belongs to the next frame.
            cnt_d = sen_i ? CntW'(1) : '0;
        end else if (sen_i && (cnt_q != CntFull)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            din_shr_q   <= '0;
            dout_shr_q  <= '0;
            din_q       <= '0;
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            din_shr_q   <= din_shr_d;
            dout_shr_q  <= dout_shr_d;
            din_q       <= din_d;
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign do_o        = dout_shr_q[DOUT_N-1];
    assign din_o       = din_q;
    assign ready_o     = (cnt_q == CntFull);
    assign frame_err_o = frame_err_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_roi_serial_harness.sv
// Randomised bench for roi_serial_harness: three parameterisations share one stimulus stream
// and are checked every cycle against a frame-level integer model, plus a few directed cases.
module tb_roi_serial_harness;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       sen_i = 1'b0;
    logic       di_i = 1'b0;
    logic       stb_i = 1'b0;
    logic [7:0] dout_r = 8'h00;

    logic       do_a, do_b, do_c;
    logic [2:0] din_a;
    logic [3:0] din_b;
    logic [0:0] din_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic       err_a, err_b, err_c;
    logic [1:0]  fc_a;
    logic [15:0] fc_b;
    logic [2:0]  fc_c;

    int n_vec = 0;
    int n_err = 0;

    // Model state per DUT: din_shr content, pending output bits (MSB is on do),
    // latched din, bits in current frame, sticky error, strobe count.
    int m_shr[3], m_oq[3], m_din[3], m_nb[3], m_err[3], m_fc[3];

    always #5 clk_i = ~clk_i;

    roi_serial_harness #(.DIN_N(3), .DOUT_N(8), .AUTO_STB(0), .CNT_W(2)) u_dut_a (
        .clk_i(clk_i), .rst_ni(rst_ni), .sen_i(sen_i), .di_i(di_i), .stb_i(stb_i),
        .do_o(do_a), .din_o(din_a), .dout_i(dout_r), .ready_o(rdy_a),
        .frame_err_o(err_a), .frame_cnt_o(fc_a)
    );

    roi_serial_harness #(.DIN_N(4), .DOUT_N(5), .AUTO_STB(1), .CNT_W(16)) u_dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .sen_i(sen_i), .di_i(di_i), .stb_i(stb_i),
        .do_o(do_b), .din_o(din_b), .dout_i(dout_r[4:0]), .ready_o(rdy_b),
        .frame_err_o(err_b), .frame_cnt_o(fc_b)
    );

    roi_serial_harness #(.DIN_N(1), .DOUT_N(1), .AUTO_STB(1), .CNT_W(3)) u_dut_c (
        .clk_i(clk_i), .rst_ni(rst_ni), .sen_i(sen_i), .di_i(di_i), .stb_i(stb_i),
        .do_o(do_c), .din_o(din_c), .dout_i(dout_r[0:0]), .ready_o(rdy_c),
        .frame_err_o(err_c), .frame_cnt_o(fc_c)
    );

    function automatic int p_din(input int k);
        case (k)
            0: return 3;
            1: return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int p_dout(input int k);
        case (k)
            0: return 8;
            1: return 5;
            default: return 1;
        endcase
    endfunction

    function automatic int p_auto(input int k);
        return (k == 0) ? 0 : 1;
    endfunction

    function automatic int p_cntw(input int k);
        case (k)
            0: return 2;
            1: return 16;
            default: return 3;
        endcase
    endfunction

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_shr[k] = 0; m_oq[k] = 0; m_din[k] = 0;
            m_nb[k] = 0; m_err[k] = 0; m_fc[k] = 0;
        end
    endtask

    task automatic model_update(input int k, input int sen, input int di, input int stb,
                                input int dr);
        int n, m, s, exit_bit;
        n = p_din(k);
        m = p_dout(k);
        s = (stb != 0 || (p_auto(k) != 0 && m_nb[k] == n)) ? 1 : 0;
        exit_bit = (m_shr[k] >> (n - 1)) & 1;
        if (s != 0) begin
            m_din[k] = m_shr[k];
            m_oq[k] = dr % (1 << m);
            if (m_nb[k] < n) m_err[k] = 1;
            m_fc[k] = (m_fc[k] + 1) % (1 << p_cntw(k));
            m_nb[k] = sen;
        end else begin
            if (sen != 0) m_oq[k] = (m_oq[k] * 2 + exit_bit) % (1 << m);
            if (sen != 0 && m_nb[k] < n) m_nb[k]++;
        end
        if (sen != 0) m_shr[k] = (m_shr[k] * 2 + di) % (1 << n);
    endtask

    task automatic compare(input int k);
        int g_do, g_din, g_rdy, g_err, g_fc;
        case (k)
            0: begin g_do = do_a; g_din = din_a; g_rdy = rdy_a; g_err = err_a; g_fc = fc_a; end
            1: begin g_do = do_b; g_din = din_b; g_rdy = rdy_b; g_err = err_b; g_fc = fc_b; end
            default: begin
                g_do = do_c; g_din = din_c; g_rdy = rdy_c; g_err = err_c; g_fc = fc_c;
            end
        endcase
        check_val($sformatf("d%0d.do", k), g_do, (m_oq[k] >> (p_dout(k) - 1)) & 1);
        check_val($sformatf("d%0d.din", k), g_din, m_din[k]);
        check_val($sformatf("d%0d.ready", k), g_rdy, (m_nb[k] == p_din(k)) ? 1 : 0);
        check_val($sformatf("d%0d.frame_err", k), g_err, m_err[k]);
        check_val($sformatf("d%0d.frame_cnt", k), g_fc, m_fc[k]);
    endtask

    task automatic step(input logic sen, input logic di, input logic stb, input logic [7:0] dr);
        sen_i = sen; di_i = di; stb_i = stb; dout_r = dr;
        @(posedge clk_i);
        #1;
        for (int k = 0; k < 3; k++) begin
            model_update(k, int'(sen), int'(di), int'(stb), int'(dr));
            compare(k);
        end
    endtask

    // Asserts reset between clock edges and checks that it acts without waiting for an edge.
    task automatic do_reset();
        #2;
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_val("rst.outputs_a", int'({do_a, din_a, rdy_a, err_a, fc_a}), 0);
        check_val("rst.outputs_b", int'({do_b, din_b, rdy_b, err_b, fc_b}), 0);
        check_val("rst.outputs_c", int'({do_c, din_c, rdy_c, err_c, fc_c}), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [7:0] pat;
        logic       sen, stb;
        pat = 8'hA5;

        #3;
        do_reset();

        // Frame 1,0,1 then strobe without shifting.
        step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        check_val("dir.ready_full", int'(rdy_a), 1);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check_val("dir.din_101", int'(din_a), 5);
        check_val("dir.ready_after_stb", int'(rdy_a), 0);
        check_val("dir.fc_one", int'(fc_a), 1);
        check_val("dir.no_err", int'(err_a), 0);

        // Captured ROI output leaves MSB first from the strobe edge on.
        step(1'b1, 1'b0, 1'b1, pat);
        check_val("dir.a5_bit7", int'(do_a), int'(pat[7]));
        for (int i = 6; i >= 0; i--) begin
            step(1'b1, 1'b0, 1'b0, 8'h00);
            check_val($sformatf("dir.a5_bit%0d", i), int'(do_a), int'(pat[i]));
        end

        // Five strobes on a 2-bit frame counter wrap to 1; the error stays set afterwards.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        check_val("dir.fc_wrap", int'(fc_a), 1);
        check_val("dir.err_short", int'(err_a), 1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        check_val("dir.err_sticky", int'(err_a), 1);

        // Hold: five sen=0 cycles with toggling di, then strobe during the hold.
        do_reset();
        step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b0, i[0], 1'b0, 8'h00);
        check_val("dir.hold_ready", int'(rdy_a), 0);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check_val("dir.hold_din", int'(din_a), 3);

        // Random traffic, biased towards clean frames on DUT A.
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            sen = ($urandom_range(0, 7) != 0);
            stb = ($urandom_range(0, 11) == 0) ||
                  (m_nb[0] == 3 && $urandom_range(0, 2) == 0);
            step(sen, 1'($urandom), stb, 8'($urandom));
            if ($urandom_range(0, 399) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
